// File: rtl/input_snapshot_ctrl_if.sv
// Shared 8-bit input RAM write port plus the ROM-download write port that competes for it.
// The master side is the snapshot controller; the slave side is the download source / RAM.
interface input_snapshot_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic              dn_wr;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_wr;

    modport master (
        input  dn_wr, dn_addr, dn_data,
        output ram_addr, ram_data, ram_wr
    );

    modport slave (
        output dn_wr, dn_addr, dn_data,
        input  ram_addr, ram_data, ram_wr
    );
endinterface

// File: rtl/input_snapshot_ctrl.sv
// Latches all player inputs on each VBlank rising edge and streams the snapshot, one byte per
// cycle, into the shared input RAM; download writes always win the port and stall the stream.
//
// state   | meaning
// IDLE    | waiting for a VBlank rising edge
// WRITE   | emitting snapshot bytes (stalls while a download write owns the port)
// DONE    | last byte issued; pulse done and count the frame
module input_snapshot_ctrl #(
    parameter int PLAYERS   = 6,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int STRIDE    = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   vblank_i,
    input  logic                   dn_active_i,
    input  logic [32*PLAYERS-1:0]  joystick_i,
    input  logic [16*PLAYERS-1:0]  analog_i,
    input  logic [8*PLAYERS-1:0]   paddle_i,
    input  logic [9*PLAYERS-1:0]   spinner_i,
    input_snapshot_ctrl_if.master  ram_if,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [15:0]            frame_count_o,
    output logic                   overrun_o
);
    localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [PW-1:0] LAST_PLAYER = PW'(PLAYERS - 1);
    localparam logic [3:0]    LAST_BYTE   = 4'd8;

    logic [1:0]        state_q, state_d;
    logic              vb_q;
    logic [PW-1:0]     player_q, player_d;
    logic [3:0]        byte_q, byte_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              ram_wr_q, ram_wr_d;
    logic              done_q, done_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              overrun_q, overrun_d;

    logic [31:0] joy_q  [PLAYERS];
    logic [15:0] ana_q  [PLAYERS];
    logic [7:0]  pad_q  [PLAYERS];
    logic [8:0]  spin_q [PLAYERS];

    logic              vb_edge;
    logic              capture;
    logic [7:0]        seq_data;
    logic [ADDR_W-1:0] seq_addr;

    assign vb_edge = vblank_i & ~vb_q;
    assign capture = vb_edge & ~dn_active_i;

    always_comb begin
        seq_data = 8'h00;
        case (byte_q)
            4'd0:    seq_data = joy_q[player_q][7:0];
            4'd1:    seq_data = joy_q[player_q][15:8];
            4'd2:    seq_data = joy_q[player_q][23:16];
            4'd3:    seq_data = joy_q[player_q][31:24];
            4'd4:    seq_data = ana_q[player_q][7:0];
            4'd5:    seq_data = ana_q[player_q][15:8];
            4'd6:    seq_data = pad_q[player_q];
            4'd7:    seq_data = spin_q[player_q][7:0];
            4'd8:    seq_data = {7'b0, spin_q[player_q][8]};
            default: seq_data = 8'h00;
        endcase
    end

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign seq_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(player_q) * ADDR_W'(STRIDE)
                    + ADDR_W'(byte_q);

    always_comb begin
        state_d       = state_q;
        player_d      = player_q;
        byte_d        = byte_q;
        done_d        = 1'b0;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    state_d  = S_WRITE;
                    player_d = '0;
                    byte_d   = '0;
                end
            end
            S_WRITE: begin
                if (!ram_if.dn_wr) begin
                    if (byte_q == LAST_BYTE) begin
                        byte_d = '0;
                        if (player_q == LAST_PLAYER) begin
                            state_d = S_DONE;
                        end else begin
                            player_d = player_q + 1'b1;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d       = S_IDLE;
                done_d        = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (capture && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Download owns the port whenever it strobes; otherwise the sequencer writes in WRITE.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wr_d   = 1'b0;
        if (ram_if.dn_wr) begin
            ram_addr_d = ram_if.dn_addr;
            ram_data_d = ram_if.dn_data;
            ram_wr_d   = 1'b1;
        end else if (state_q == S_WRITE) begin
            ram_addr_d = seq_addr;
            ram_data_d = seq_data;
            ram_wr_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= S_IDLE;
            vb_q          <= 1'b0;
            player_q      <= '0;
            byte_q        <= '0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            ram_wr_q      <= 1'b0;
            done_q        <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vb_q          <= vblank_i;
            player_q      <= player_d;
            byte_q        <= byte_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            ram_wr_q      <= ram_wr_d;
            done_q        <= done_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
        end
    end

    // Snapshot is only taken from IDLE so a late edge cannot tear an in-flight frame.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int p = 0; p < PLAYERS; p++) begin
                joy_q[p]  <= '0;
                ana_q[p]  <= '0;
                pad_q[p]  <= '0;
                spin_q[p] <= '0;
            end
        end else if ((state_q == S_IDLE) && capture) begin
            for (int p = 0; p < PLAYERS; p++) begin
                joy_q[p]  <= joystick_i[32*p +: 32];
                ana_q[p]  <= analog_i[16*p +: 16];
                pad_q[p]  <= paddle_i[8*p +: 8];
                spin_q[p] <= spinner_i[9*p +: 9];
            end
        end
    end

    assign ram_if.ram_addr = ram_addr_q;
    assign ram_if.ram_data = ram_data_q;
    assign ram_if.ram_wr   = ram_wr_q;
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign frame_count_o   = frame_count_q;
    assign overrun_o       = overrun_q;
endmodule

// File: tb/tb_input_snapshot_ctrl.sv
// Scoreboard bench for input_snapshot_ctrl: expected RAM writes are queued from a reference
// model of the byte map and popped as the DUT writes.
module tb_input_snapshot_ctrl;
    localparam int PLAYERS   = 6;
    localparam int ADDR_W    = 8;
    localparam int BASE_ADDR = 0;
    localparam int STRIDE    = 16;
    localparam int NBYTES    = 9 * PLAYERS;

    logic                  clk_sys   = 1'b0;
    logic                  reset     = 1'b1;
    logic                  vblank    = 1'b0;
    logic                  dn_active = 1'b0;
    logic [32*PLAYERS-1:0] joystick  = '0;
    logic [16*PLAYERS-1:0] analog    = '0;
    logic [8*PLAYERS-1:0]  paddle    = '0;
    logic [9*PLAYERS-1:0]  spinner   = '0;
    logic                  busy;
    logic                  done;
    logic [15:0]           frame_count;
    logic                  overrun;

    input_snapshot_ctrl_if #(.ADDR_W(ADDR_W)) ram_if ();

    input_snapshot_ctrl #(
        .PLAYERS  (PLAYERS),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .STRIDE   (STRIDE)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .vblank_i     (vblank),
        .dn_active_i  (dn_active),
        .joystick_i   (joystick),
        .analog_i     (analog),
        .paddle_i     (paddle),
        .spinner_i    (spinner),
        .ram_if       (ram_if),
        .busy_o       (busy),
        .done_o       (done),
        .frame_count_o(frame_count),
        .overrun_o    (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int done_count = 0;
    int done_cyc = 0;
    logic prev_done = 1'b0;

    logic [31:0] m_joy  [PLAYERS];
    logic [15:0] m_ana  [PLAYERS];
    logic [7:0]  m_pad  [PLAYERS];
    logic [8:0]  m_spin [PLAYERS];
    logic [15:0] exp_q[$];

    // One clock: sample at the falling edge (cyc = index of the last rising edge) and score writes.
    task automatic step();
        logic [15:0] e;
        @(negedge clk_sys);
        cyc++;
        if (ram_if.ram_wr === 1'b1) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write: cycle %0d got addr=%h data=%h, required no write",
                         cyc, ram_if.ram_addr, ram_if.ram_data);
            end else begin
                e = exp_q.pop_front();
                if ({ram_if.ram_addr, ram_if.ram_data} !== e) begin
                    errors++;
                    $display("FAIL sb_write: cycle %0d got addr=%h data=%h, required addr=%h data=%h",
                             cyc, ram_if.ram_addr, ram_if.ram_data, e[15:8], e[7:0]);
                end
            end
        end
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
            checks++;
            if (prev_done === 1'b1) begin
                errors++;
                $display("FAIL done_width: done high at cycles %0d and %0d, required one-cycle pulse",
                         cyc - 1, cyc);
            end
        end
        prev_done = done;
    endtask

    function automatic logic [7:0] exp_byte(int p, int b);
        case (b)
            0: return m_joy[p][7:0];
            1: return m_joy[p][15:8];
            2: return m_joy[p][23:16];
            3: return m_joy[p][31:24];
            4: return m_ana[p][7:0];
            5: return m_ana[p][15:8];
            6: return m_pad[p];
            7: return m_spin[p][7:0];
            default: return {7'b0, m_spin[p][8]};
        endcase
    endfunction

    task automatic push_seq(int from, int to);
        int p;
        int b;
        logic [7:0] a;
        for (int k = from; k <= to; k++) begin
            p = k / 9;
            b = k % 9;
            a = 8'(BASE_ADDR + p * STRIDE + b);
            exp_q.push_back({a, exp_byte(p, b)});
        end
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < PLAYERS; p++) begin
            joystick[32*p +: 32] = m_joy[p];
            analog[16*p +: 16]   = m_ana[p];
            paddle[8*p +: 8]     = m_pad[p];
            spinner[9*p +: 9]    = m_spin[p];
        end
    endtask

    task automatic randomize_models();
        for (int p = 0; p < PLAYERS; p++) begin
            m_joy[p]  = $urandom;
            m_ana[p]  = 16'($urandom);
            m_pad[p]  = 8'($urandom);
            m_spin[p] = 9'($urandom);
        end
        drive_inputs();
    endtask

    // Raise vblank so the DUT samples the rising edge at rising clock edge n.
    task automatic start_capture(output int n);
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        n = cyc + 1;
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = done_count;
        for (int i = 0; i < budget && done_count == start; i++) step();
        checks++;
        if (done_count == start) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks += 7;
        if (ram_if.ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr: got %b, required 0", ram_if.ram_wr); end
        if (ram_if.ram_addr !== 8'h00) begin errors++; $display("FAIL reset_ram_addr: got %h, required 00", ram_if.ram_addr); end
        if (ram_if.ram_data !== 8'h00) begin errors++; $display("FAIL reset_ram_data: got %h, required 00", ram_if.ram_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        if (frame_count !== 16'h0000) begin errors++; $display("FAIL reset_frame_count: got %h, required 0000", frame_count); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int n;
        int wr0;
        int dc0;
        for (int p = 0; p < PLAYERS; p++) begin
            m_joy[p] = '0; m_ana[p] = '0; m_pad[p] = '0; m_spin[p] = '0;
        end
        m_joy[0] = 32'h11223344; m_ana[0] = 16'hA55A; m_pad[0] = 8'h7F; m_spin[0] = 9'h1FF;
        drive_inputs();
        push_seq(0, NBYTES - 1);
        wr0 = wr_count;
        start_capture(n);
        step();
        step();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b at N+1, required 1", busy); end
        if (wr_count - wr0 !== 1) begin errors++; $display("FAIL basic_first_write: got %0d writes by N+1, required 1", wr_count - wr0); end
        wait_done(200);
        checks += 5;
        if (done_cyc !== n + 1 + NBYTES) begin errors++; $display("FAIL basic_done_cycle: got N+%0d, required N+%0d", done_cyc - n, 1 + NBYTES); end
        if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frame_count: got %0d, required 1", frame_count); end
        if (wr_count - wr0 !== NBYTES) begin errors++; $display("FAIL basic_write_count: got %0d, required %0d", wr_count - wr0, NBYTES); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_sb_left: got %0d pending, required 0", exp_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b, required 0", busy); end
        // vblank stays high: no second capture
        wr0 = wr_count;
        dc0 = done_count;
        repeat (10) step();
        checks += 3;
        if (wr_count !== wr0) begin errors++; $display("FAIL held_vblank_writes: got %0d, required 0", wr_count - wr0); end
        if (done_count !== dc0) begin errors++; $display("FAIL held_vblank_done: got %0d, required 0", done_count - dc0); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL held_vblank_overrun: got %b, required 0", overrun); end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_download_priority();
        int n;
        logic [15:0] fc0;
        fc0 = frame_count;
        randomize_models();
        ram_if.dn_wr = 1'b1; ram_if.dn_addr = 8'h90; ram_if.dn_data = 8'h5A;
        exp_q.push_back(16'h905A);
        step();
        ram_if.dn_wr = 1'b0;
        step();
        checks += 2;
        if (ram_if.ram_wr !== 1'b0) begin errors++; $display("FAIL idle_dn_release: got ram_wr=%b, required 0", ram_if.ram_wr); end
        if ({ram_if.ram_addr, ram_if.ram_data} !== 16'h905A) begin errors++; $display("FAIL idle_hold: got %h, required 905A", {ram_if.ram_addr, ram_if.ram_data}); end
        push_seq(0, 3);
        repeat (3) exp_q.push_back(16'h80EE);
        push_seq(4, NBYTES - 1);
        start_capture(n);
        while (cyc < n + 4) step();
        ram_if.dn_wr = 1'b1; ram_if.dn_addr = 8'h80; ram_if.dn_data = 8'hEE;
        repeat (3) step();
        ram_if.dn_wr = 1'b0;
        wait_done(200);
        checks += 4;
        if (done_cyc !== n + 4 + NBYTES) begin errors++; $display("FAIL dn_done_cycle: got N+%0d, required N+%0d", done_cyc - n, 4 + NBYTES); end
        if (frame_count !== fc0 + 16'd1) begin errors++; $display("FAIL dn_frame_count: got %0d, required %0d", frame_count, fc0 + 16'd1); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL dn_sb_left: got %0d pending, required 0", exp_q.size()); end
        if ({ram_if.ram_addr, ram_if.ram_data} !== {8'h58, exp_byte(PLAYERS - 1, 8)}) begin
            errors++;
            $display("FAIL dn_hold_last: got %h, required %h", {ram_if.ram_addr, ram_if.ram_data}, {8'h58, exp_byte(PLAYERS - 1, 8)});
        end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_suppression();
        int wr0;
        vblank = 1'b0;
        step();
        dn_active = 1'b1;
        vblank = 1'b1;
        wr0 = wr_count;
        repeat (20) begin
            step();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL supp_busy: cycle %0d got %b, required 0", cyc, busy); end
        end
        dn_active = 1'b0;
        repeat (5) step();
        checks += 2;
        if (wr_count !== wr0) begin errors++; $display("FAIL supp_writes: got %0d, required 0", wr_count - wr0); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL supp_overrun: got %b, required 0", overrun); end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_overrun();
        int n;
        logic [15:0] fc0;
        fc0 = frame_count;
        randomize_models();
        push_seq(0, NBYTES - 1);
        start_capture(n);
        while (cyc < n + 2) step();
        vblank = 1'b0;
        while (cyc < n + 9) step();
        joystick = ~joystick;
        while (cyc < n + 19) step();
        vblank = 1'b1;
        wait_done(200);
        checks += 4;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b, required 1", overrun); end
        if (frame_count !== fc0 + 16'd1) begin errors++; $display("FAIL ovr_frame_count: got %0d, required %0d", frame_count, fc0 + 16'd1); end
        if (done_cyc !== n + 1 + NBYTES) begin errors++; $display("FAIL ovr_done_cycle: got N+%0d, required N+%0d", done_cyc - n, 1 + NBYTES); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL ovr_sb_left: got %0d pending, required 0", exp_q.size()); end
        vblank = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks += 2;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared: got %b, required 0", overrun); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL ovr_reset_fc: got %0d, required 0", frame_count); end
    endtask

    task automatic test_reset_mid();
        int n;
        int wr0;
        int dc0;
        randomize_models();
        push_seq(0, 28);
        start_capture(n);
        while (cyc < n + 2) step();
        vblank = 1'b0;
        while (cyc < n + 29) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (ram_if.ram_wr !== 1'b0) begin errors++; $display("FAIL mid_ram_wr_n30: got %b, required 0", ram_if.ram_wr); end
        wr0 = wr_count;
        dc0 = done_count;
        repeat (60) begin
            step();
            checks++;
            if (ram_if.ram_wr !== 1'b0) begin errors++; $display("FAIL mid_ram_wr: cycle N+%0d got %b, required 0", cyc - n, ram_if.ram_wr); end
        end
        checks += 4;
        if (done_count !== dc0) begin errors++; $display("FAIL mid_done: got %0d pulses, required 0", done_count - dc0); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL mid_frame_count: got %0d, required 0", frame_count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_sb_left: got %0d pending, required 0", exp_q.size()); end
        push_seq(0, NBYTES - 1);
        start_capture(n);
        wait_done(200);
        checks += 2;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL mid_restart_fc: got %0d, required 1", frame_count); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_restart_sb: got %0d pending, required 0", exp_q.size()); end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        int n;
        int dc0;
        force dut.frame_count_q = 16'hFFFF;
        step();
        release dut.frame_count_q;
        step();
        checks++;
        if (frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h, required FFFF", frame_count); end
        randomize_models();
        push_seq(0, NBYTES - 1);
        dc0 = done_count;
        start_capture(n);
        wait_done(200);
        checks++;
        if (frame_count !== 16'h0000) begin errors++; $display("FAIL wrap_fc: got %h, required 0000", frame_count); end
        repeat (3) step();
        checks += 2;
        if (done_count - dc0 !== 1) begin errors++; $display("FAIL wrap_done_count: got %0d cycles, required 1", done_count - dc0); end
        if (done !== 1'b0) begin errors++; $display("FAIL wrap_done_low: got %b, required 0", done); end
        vblank = 1'b0;
        step();
    endtask

    initial begin
        ram_if.dn_wr   = 1'b0;
        ram_if.dn_addr = '0;
        ram_if.dn_data = '0;
        test_reset();
        test_basic();
        test_download_priority();
        test_suppression();
        test_overrun();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_snapshot_ctrl.md
Name: input_snapshot_ctrl

Overview:
- Captures all player input state (joystick, analog, paddle, spinner) at each VBlank rising edge.
- Sequences the snapshot byte-by-byte into the system's shared 8-bit input RAM write port.
- Arbitrates that port against ROM-download writes; download always has priority.
- Sits between hps_io outputs and the system block.

Parameters:
PLAYERS, 6, number of player slots captured
ADDR_W, 8, RAM address width
BASE_ADDR, 0, RAM address of player 0 record
STRIDE, 16, bytes per player record (must be >= 9, power of two)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous active-high reset
vblank  in  1  video vertical blank
dn_active  in  1  download in progress; suppresses new captures
joystick  in  32*PLAYERS  digital buttons, player 0 in LSBs
analog  in  16*PLAYERS  per player: [7:0] X, [15:8] Y
paddle  in  8*PLAYERS  paddle positions
spinner  in  9*PLAYERS  spinner values
dn_wr  in  1  download write strobe
dn_addr  in  ADDR_W  download write address
dn_data  in  8  download write data
ram_addr  out  ADDR_W  shared RAM write address
ram_data  out  8  shared RAM write data
ram_wr  out  1  shared RAM write strobe
busy  out  1  sequence in progress
done  out  1  one-cycle pulse, snapshot fully written
frame_count  out  16  completed snapshots
overrun  out  1  sticky; a VBlank edge arrived while busy

Behaviour:
- Reset values: all outputs 0, state IDLE, snapshot registers 0, vblank history register 0.
- Edge detect:
  - edge = vblank & ~vb_q, with vb_q registered every cycle.
  - An edge with dn_active=1 is ignored and does not set overrun.
- States:
  - IDLE: on edge, latch all inputs into the snapshot in that clock; clear player/byte counters; go to WRITE.
  - WRITE: emit one byte per cycle with dn_wr=0; go to DONE after player PLAYERS-1, byte 8.
  - DONE: one cycle; done=1, frame_count+1 (wraps 0xFFFF->0); return to IDLE.
- busy=1 in WRITE and DONE.
- Address: ram_addr = BASE_ADDR + player*STRIDE + byte, truncated to ADDR_W.
- Byte map:
  - 0..3: joystick[7:0], [15:8], [23:16], [31:24]
  - 4: analog[7:0]
  - 5: analog[15:8]
  - 6: paddle
  - 7: spinner[7:0]
  - 8: {7'b0, spinner[8]}
  - Bytes 9..STRIDE-1 are never written.
- Arbitration (combinational mux, registered outputs):
  - When dn_wr=1 in any state: next ram_addr/ram_data = dn_addr/dn_data, ram_wr=1; the sequencer holds its counters (stall, no byte lost or repeated).
  - When dn_wr=0 in WRITE: the sequencer byte is driven with ram_wr=1.
  - Otherwise ram_wr=0; ram_addr/ram_data hold their last value.
- Latency:
  - vblank rises at cycle N (sampled at edge N) → first sequencer write visible cycle N+1.
  - Unstalled: 9*PLAYERS writes (54 cycles at default), done at cycle N+1+9*PLAYERS.
  - Each dn_wr cycle during WRITE adds one cycle.
- Edge while busy (WRITE or DONE): ignored; overrun set to 1; cleared only by reset. The snapshot is not re-latched mid-sequence, so data stays coherent.
- Inputs changing during WRITE do not affect written data.
- Reset mid-sequence: next cycle IDLE, ram_wr=0, no further writes, frame_count=0, overrun=0.
- vblank held high: only one capture per rising edge.

Test Plan:
- Basic capture:
  - Stimulus: player0 joystick=0x11223344, analog=0xA55A, paddle=0x7F, spinner=0x1FF, others 0; one vblank rise.
  - Required: 54 writes; addr 0..3 = 44,33,22,11; 4=5A; 5=A5; 6=7F; 7=FF; 8=01; player1 at 0x10..0x18; done once; frame_count=1.
- Download priority:
  - Stimulus: dn_wr=1 (addr 0x80, data 0xEE) for 3 cycles starting at the 5th sequencer write.
  - Required: three writes of 0xEE@0x80; the sequence resumes at byte 4 without gap or repeat; done at N+58.
- Overrun / coherency:
  - Stimulus: second vblank edge at cycle N+20; change joystick at N+10.
  - Required: overrun=1; original values written; frame_count=1; after reset overrun=0.
- Suppression:
  - Stimulus: dn_active=1 during a vblank edge.
  - Required: no writes, busy=0, overrun=0.
- Reset mid-sequence:
  - Stimulus: reset at N+30.
  - Required: ram_wr=0 from N+31; no done; frame_count=0; the next edge restarts at addr BASE_ADDR.
- Wrap:
  - Stimulus: preload 65535 completed frames (or force counter), run one more.
  - Required: frame_count=0, done pulses exactly one cycle.
